// File: rtl/pipe_dff.sv
// pipe_dff: stallable, flushable WIDTH x DEPTH register pipeline with per-stage
// valid bits, a selectable tap output and a registered occupancy count.
module pipe_dff #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_valid,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // Occupancy after a shift: one entry enters stage 0, one leaves the last stage.
  always_comb begin
    count_nxt_s = count_r;
    case ({d_valid, vld_r[DEPTH-1]})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Stage and count registers; flush outranks shift, shift outranks hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_r[i] <= RESET_VALUE;
      vld_r   <= {DEPTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) data_r[i] <= RESET_VALUE;
      vld_r   <= {DEPTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      data_r[0] <= d;
      vld_r[0]  <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_r[i] <= data_r[i-1];
        vld_r[i]  <= vld_r[i-1];
      end
      count_r <= count_nxt_s;
    end else begin
      count_r <= count_r;
    end
  end

  // Tap mux reads stage registers only; out-of-range selects give the reset value.
  always_comb begin
    tap_q     = RESET_VALUE;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        tap_q     = data_r[i];
        tap_valid = vld_r[i];
      end else begin
        tap_q     = tap_q;
        tap_valid = tap_valid;
      end
    end
  end

  assign q       = data_r[DEPTH-1];
  assign q_valid = vld_r[DEPTH-1];
  assign count   = count_r;

endmodule

// File: tb/tb_pipe_dff.sv
// Bench for pipe_dff: three instances (DEPTH 4, 3, 1) share stimulus and are
// compared against queue-based reference models of the pipeline contents.
module tb_pipe_dff;

  localparam logic [7:0] RV4 = 8'h00;
  localparam logic [7:0] RV3 = 8'h5A;
  localparam logic [7:0] RV1 = 8'hC3;

  typedef logic [8:0] ent_t;  // {valid, data}

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       d_valid = 1'b0;
  logic [7:0] d = 8'h00;
  logic [1:0] sel4 = 2'd0;
  logic [1:0] sel3 = 2'd0;
  logic       sel1 = 1'b0;

  logic [7:0] q4, tq4, q3, tq3, q1, tq1;
  logic       qv4, tv4, qv3, tv3, qv1, tv1;
  logic [2:0] c4;
  logic [1:0] c3;
  logic [0:0] c1;

  int tests = 0;
  int fails = 0;

  ent_t m4[$];
  ent_t m3[$];
  ent_t m1[$];

  always #5 clk = ~clk;

  pipe_dff #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(RV4)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .tap_sel(sel4), .q(q4), .q_valid(qv4), .tap_q(tq4), .tap_valid(tv4), .count(c4));

  pipe_dff #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(RV3)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .tap_sel(sel3), .q(q3), .q_valid(qv3), .tap_q(tq3), .tap_valid(tv3), .count(c3));

  pipe_dff #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(RV1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .tap_sel(sel1), .q(q1), .q_valid(qv1), .tap_q(tq1), .tap_valid(tv1), .count(c1));

  function automatic int popv(input ent_t qq[$]);
    int n = 0;
    foreach (qq[i]) n += qq[i][8] ? 1 : 0;
    return n;
  endfunction

  function automatic ent_t tap_exp(input ent_t qq[$], input int sel, input logic [7:0] rv);
    if (sel < qq.size()) return qq[sel];
    return {1'b0, rv};
  endfunction

  task automatic model_clear();
    m4.delete(); m3.delete(); m1.delete();
    for (int i = 0; i < 4; i++) m4.push_back({1'b0, RV4});
    for (int i = 0; i < 3; i++) m3.push_back({1'b0, RV3});
    m1.push_back({1'b0, RV1});
  endtask

  task automatic model_shift(input ent_t e);
    m4.push_front(e); void'(m4.pop_back());
    m3.push_front(e); void'(m3.pop_back());
    m1.push_front(e); void'(m1.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst || flush) model_clear();
    else if (en) model_shift({d_valid, d});
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    model_clear();
    tests++;
    if ({qv4, q4, c4, tv4, tq4} !== {1'b0, RV4, 3'd0, 1'b0, RV4}) begin
      fails++; $display("FAIL reset_d4: got %h expected %h", {qv4, q4, c4, tv4, tq4}, {1'b0, RV4, 3'd0, 1'b0, RV4});
    end
    tests++;
    if ({qv3, q3, c3, qv1, q1, c1} !== {1'b0, RV3, 2'd0, 1'b0, RV1, 1'b0}) begin
      fails++; $display("FAIL reset_d3_d1: got %h expected %h", {qv3, q3, c3, qv1, q1, c1}, {1'b0, RV3, 2'd0, 1'b0, RV1, 1'b0});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    int exp_c [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d_valid = (k < 4);
      d = (k < 4) ? exp_q[k] : 8'h00;
      tick();
      tests++;
      if (c4 !== 3'(exp_c[k])) begin
        fails++; $display("FAIL fill_count edge %0d: got %0d expected %0d", k + 1, c4, exp_c[k]);
      end
      if (k >= 3 && k <= 6) begin
        tests++;
        if ({qv4, q4} !== {1'b1, exp_q[k-3]}) begin
          fails++; $display("FAIL fill_q edge %0d: got %h expected %h", k + 1, {qv4, q4}, {1'b1, exp_q[k-3]});
        end
      end
    end
  endtask

  task automatic test_stall();
    flush = 1'b1; tick(); flush = 1'b0;
    en = 1'b1; d_valid = 1'b1; d = 8'hA5; sel4 = 2'd0;
    tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom); d_valid = 1'b1;
      tick();
      tests++;
      if ({tv4, tq4, c4, qv4} !== {1'b1, 8'hA5, 3'd1, 1'b0}) begin
        fails++; $display("FAIL stall_hold cyc %0d: got %h expected %h", k, {tv4, tq4, c4, qv4}, {1'b1, 8'hA5, 3'd1, 1'b0});
      end
    end
    en = 1'b1; d_valid = 1'b0; d = 8'h00;
    tick(); tick();
    tests++;
    if (qv4 !== 1'b0) begin
      fails++; $display("FAIL stall_early: got qv=%0b expected 0", qv4);
    end
    tick();
    tests++;
    if ({qv4, q4, c4} !== {1'b1, 8'hA5, 3'd1}) begin
      fails++; $display("FAIL stall_out: got %h expected %h", {qv4, q4, c4}, {1'b1, 8'hA5, 3'd1});
    end
  endtask

  task automatic test_flush_priority();
    en = 1'b1; d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'h10 + 8'(k);
      tick();
    end
    tests++;
    if (c4 !== 3'd4) begin
      fails++; $display("FAIL flush_full: got %0d expected 4", c4);
    end
    flush = 1'b1; en = 1'b1; d = 8'hFF; d_valid = 1'b1;
    tick();
    flush = 1'b0;
    tests++;
    if ({qv4, q4, c4, qv3, q3, c3} !== {1'b0, RV4, 3'd0, 1'b0, RV3, 2'd0}) begin
      fails++; $display("FAIL flush_out: got %h expected %h", {qv4, q4, c4, qv3, q3, c3}, {1'b0, RV4, 3'd0, 1'b0, RV3, 2'd0});
    end
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      #1;
      tests++;
      if ({tv4, tq4} !== {1'b0, RV4}) begin
        fails++; $display("FAIL flush_tap sel %0d: got %h expected %h", s, {tv4, tq4}, {1'b0, RV4});
      end
    end
  endtask

  task automatic test_tap_select();
    ent_t e4 [4] = '{{1'b1, 8'h03}, {1'b1, 8'h02}, {1'b1, 8'h01}, {1'b0, RV4}};
    ent_t e3 [4] = '{{1'b1, 8'h03}, {1'b1, 8'h02}, {1'b1, 8'h01}, {1'b0, RV3}};
    flush = 1'b1; tick(); flush = 1'b0;
    en = 1'b1; d_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      d = 8'(k);
      tick();
    end
    en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s); sel3 = 2'(s);
      #1;
      tests++;
      if ({tv4, tq4} !== e4[s]) begin
        fails++; $display("FAIL tap_d4 sel %0d: got %h expected %h", s, {tv4, tq4}, e4[s]);
      end
      tests++;
      if ({tv3, tq3} !== e3[s]) begin
        fails++; $display("FAIL tap_d3 sel %0d: got %h expected %h", s, {tv3, tq3}, e3[s]);
      end
    end
  endtask

  task automatic test_depth1();
    flush = 1'b1; tick(); flush = 1'b0;
    en = 1'b1; d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'(k % 2);
      tick();
      tests++;
      if ({qv1, q1, c1} !== {1'b1, 8'(k % 2), 1'b1}) begin
        fails++; $display("FAIL depth1 edge %0d: got %h expected %h", k, {qv1, q1, c1}, {1'b1, 8'(k % 2), 1'b1});
      end
    end
    sel1 = 1'b1;
    #1;
    tests++;
    if ({tv1, tq1} !== {1'b0, RV1}) begin
      fails++; $display("FAIL depth1_tap_oor: got %h expected %h", {tv1, tq1}, {1'b0, RV1});
    end
    sel1 = 1'b0;
  endtask

  task automatic test_async_reset();
    en = 1'b1; d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      tick();
    end
    sel4 = 2'd0;
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({qv4, q4, c4, tv4, tq4, qv3, q3} !== {1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, RV3}) begin
      fails++; $display("FAIL async_reset: got %h expected %h", {qv4, q4, c4, tv4, tq4, qv3, q3}, {1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, RV3});
    end
    d = 8'h77;
    tick();
    tests++;
    if (c4 !== 3'd0) begin
      fails++; $display("FAIL reset_hold: got %0d expected 0", c4);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({c4, tv4, tq4} !== {3'd1, 1'b1, 8'h77}) begin
      fails++; $display("FAIL reset_release: got %h expected %h", {c4, tv4, tq4}, {3'd1, 1'b1, 8'h77});
    end
  endtask

  task automatic test_random();
    logic [20:0] x4;
    logic [19:0] x3;
    logic [18:0] x1;
    for (int k = 0; k < 400; k++) begin
      en      = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      d_valid = 1'($urandom);
      d       = 8'($urandom);
      sel4    = 2'($urandom);
      sel3    = 2'($urandom);
      sel1    = 1'($urandom);
      tick();
      x4 = {m4[3], tap_exp(m4, int'(sel4), RV4), 3'(popv(m4))};
      x3 = {m3[2], tap_exp(m3, int'(sel3), RV3), 2'(popv(m3))};
      x1 = {m1[0], tap_exp(m1, int'(sel1), RV1), 1'(popv(m1))};
      tests++;
      if ({qv4, q4, tv4, tq4, c4} !== x4) begin
        fails++; $display("FAIL rand_d4 cyc %0d: got %h expected %h", k, {qv4, q4, tv4, tq4, c4}, x4);
      end
      tests++;
      if ({qv3, q3, tv3, tq3, c3} !== x3) begin
        fails++; $display("FAIL rand_d3 cyc %0d: got %h expected %h", k, {qv3, q3, tv3, tq3, c3}, x3);
      end
      tests++;
      if ({qv1, q1, tv1, tq1, c1} !== x1) begin
        fails++; $display("FAIL rand_d1 cyc %0d: got %h expected %h", k, {qv1, q1, tv1, tq1, c1}, x1);
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stall();
    test_flush_priority();
    test_tap_select();
    test_depth1();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
